jtag_tap_ctrl: RTL and testbench

IEEE 1149.1 TAP controller for the DCD JTAG port. It holds the 16-state TAP FSM, the instruction register and the 32-bit IDCODE data register. It produces the state strobes, latched instruction, IR serial output and IDCODE serial output that feed the TDO output multiplexer and tristate logic. It also decodes the instruction into data-register select lines for the global and pixel shift registers.

---
 rtl/jtag_tap_ctrl.sv | 149 ++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller for the DCD JTAG port.
// Holds the 16-state TAP FSM, the instruction register, the latched
// (active) instruction and the 32-bit IDCODE data register, and decodes
// the active instruction into data-register select lines.
module jtag_tap_ctrl #(
  parameter int          IR_LENGTH    = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1DC0D001
) (
  input  logic                 tck,
  input  logic                 trst,
  input  logic                 tms,
  input  logic                 tdi,
  output logic                 state_test_logic_reset,
  output logic                 state_run_test_idle,
  output logic                 state_capture_dr,
  output logic                 state_shift_dr,
  output logic                 state_pause_dr,
  output logic                 state_update_dr,
  output logic                 state_shift_ir,
  output logic                 state_exit1_ir,
  output logic                 state_update_ir,
  output logic                 instruction_tdo,
  output logic                 idcode_tdo,
  output logic [IR_LENGTH-1:0] latched_jtag_ir,
  output logic                 sel_global_sr,
  output logic                 sel_pixel_sr,
  output logic                 sel_bs_chain
);

  // TAP state encoding (binary, one code per IEEE 1149.1 state)
  localparam logic [3:0] TLR    = 4'h0;
  localparam logic [3:0] RTI    = 4'h1;
  localparam logic [3:0] SEL_DR = 4'h2;
  localparam logic [3:0] CAP_DR = 4'h3;
  localparam logic [3:0] SH_DR  = 4'h4;
  localparam logic [3:0] EX1_DR = 4'h5;
  localparam logic [3:0] PAU_DR = 4'h6;
  localparam logic [3:0] EX2_DR = 4'h7;
  localparam logic [3:0] UPD_DR = 4'h8;
  localparam logic [3:0] SEL_IR = 4'h9;
  localparam logic [3:0] CAP_IR = 4'hA;
  localparam logic [3:0] SH_IR  = 4'hB;
  localparam logic [3:0] EX1_IR = 4'hC;
  localparam logic [3:0] PAU_IR = 4'hD;
  localparam logic [3:0] EX2_IR = 4'hE;
  localparam logic [3:0] UPD_IR = 4'hF;

  // Instruction codes
  localparam logic [IR_LENGTH-1:0] IR_IDCODE     = IR_LENGTH'(4'b0010);
  localparam logic [IR_LENGTH-1:0] IR_CAPTURE    = IR_LENGTH'(4'b0001);
  localparam logic [IR_LENGTH-1:0] IR_GLOBAL_SR  = IR_LENGTH'(4'b0100);
  localparam logic [IR_LENGTH-1:0] IR_PIXEL_SR   = IR_LENGTH'(4'b1000);
  localparam logic [IR_LENGTH-1:0] IR_EXTEST     = IR_LENGTH'(4'b0000);
  localparam logic [IR_LENGTH-1:0] IR_SAMPLE_PRE = IR_LENGTH'(4'b0001);

  logic [3:0]           state_q, state_d;
  logic [IR_LENGTH-1:0] jtag_ir_q, jtag_ir_d;
  logic [IR_LENGTH-1:0] latched_ir_q, latched_ir_d, latched_ir_upd;
  logic [31:0]          idcode_q, idcode_d;

  // TAP next-state function driven by tms
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tms ? TLR    : RTI;
      RTI:     state_d = tms ? SEL_DR : RTI;
      SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
      SH_DR:   state_d = tms ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tms ? SEL_DR : RTI;
      SEL_IR:  state_d = tms ? TLR    : CAP_IR;
      CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
      SH_IR:   state_d = tms ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Instruction register capture/shift and active-instruction update
  always_comb begin
    jtag_ir_d      = jtag_ir_q;
    latched_ir_upd = latched_ir_q;
    case (state_q)
      CAP_IR:  jtag_ir_d      = IR_CAPTURE;
      SH_IR:   jtag_ir_d      = {tdi, jtag_ir_q[IR_LENGTH-1:1]};
      UPD_IR:  latched_ir_upd = jtag_ir_q;
      default: jtag_ir_d      = jtag_ir_q;
    endcase
    // Landing in (or staying in) Test-Logic-Reset forces IDCODE active
    latched_ir_d = (state_d == TLR) ? IR_IDCODE : latched_ir_upd;
  end

  // IDCODE data register: only responds while IDCODE is the active instruction
  always_comb begin
    idcode_d = idcode_q;
    if (latched_ir_q == IR_IDCODE) begin
      case (state_q)
        CAP_DR:  idcode_d = IDCODE_VALUE;
        SH_DR:   idcode_d = {tdi, idcode_q[31:1]};
        default: idcode_d = idcode_q;
      endcase
    end else begin
      idcode_d = idcode_q;
    end
  end

  // State and register update; trst aborts any scan immediately
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state_q      <= TLR;
      jtag_ir_q    <= '0;
      latched_ir_q <= IR_IDCODE;
      idcode_q     <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      jtag_ir_q    <= jtag_ir_d;
      latched_ir_q <= latched_ir_d;
      idcode_q     <= idcode_d;
    end
  end

  // State strobes are pure decodes of the state register
  assign state_test_logic_reset = (state_q == TLR);
  assign state_run_test_idle    = (state_q == RTI);
  assign state_capture_dr       = (state_q == CAP_DR);
  assign state_shift_dr         = (state_q == SH_DR);
  assign state_pause_dr         = (state_q == PAU_DR);
  assign state_update_dr        = (state_q == UPD_DR);
  assign state_shift_ir         = (state_q == SH_IR);
  assign state_exit1_ir         = (state_q == EX1_IR);
  assign state_update_ir        = (state_q == UPD_IR);

  // Serial outputs; the downstream TDO mux retimes them on negedge
  assign instruction_tdo = jtag_ir_q[0];
  assign idcode_tdo      = idcode_q[0];
  assign latched_jtag_ir = latched_ir_q;

  // Data-register selects; unknown codes give all-zero (BYPASS downstream)
  assign sel_global_sr = (latched_ir_q == IR_GLOBAL_SR);
  assign sel_pixel_sr  = (latched_ir_q == IR_PIXEL_SR);
  assign sel_bs_chain  = (latched_ir_q == IR_EXTEST) || (latched_ir_q == IR_SAMPLE_PRE);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed testbench for jtag_tap_ctrl: TAP navigation, IR load,
// IDCODE scan, pause hold, tms reset and asynchronous trst.
module tb_jtag_tap_ctrl;

  logic       tck = 1'b0;
  logic       trst = 1'b0;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic       s_tlr, s_rti, s_cdr, s_sdr, s_pdr, s_udr, s_sir, s_e1ir, s_uir;
  logic       instruction_tdo, idcode_tdo;
  logic [3:0] latched_jtag_ir;
  logic       sel_global_sr, sel_pixel_sr, sel_bs_chain;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] IDC = 32'h1DC0D001;

  jtag_tap_ctrl #(.IR_LENGTH(4), .IDCODE_VALUE(IDC)) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi),
    .state_test_logic_reset(s_tlr), .state_run_test_idle(s_rti),
    .state_capture_dr(s_cdr), .state_shift_dr(s_sdr), .state_pause_dr(s_pdr),
    .state_update_dr(s_udr), .state_shift_ir(s_sir), .state_exit1_ir(s_e1ir),
    .state_update_ir(s_uir), .instruction_tdo(instruction_tdo),
    .idcode_tdo(idcode_tdo), .latched_jtag_ir(latched_jtag_ir),
    .sel_global_sr(sel_global_sr), .sel_pixel_sr(sel_pixel_sr),
    .sel_bs_chain(sel_bs_chain)
  );

  always #5 tck = ~tck;

  // Count one comparison and report it if observed differs from expected
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One TCK cycle: drive on negedge, sample 1 ns after the posedge
  task automatic step(input logic tms_v, input logic tdi_v);
    @(negedge tck);
    tms = tms_v;
    tdi = tdi_v;
    @(posedge tck);
    #1;
  endtask

  // From RTI: full IR scan of a 4-bit value (LSB first), ending back in RTI
  task automatic load_ir(input logic [3:0] v);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step((i == 3) ? 1'b1 : 1'b0, v[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  logic [31:0] stream;
  logic [3:0]  ir_stream;
  logic [31:0] exp_id;

  initial begin
    // ---------------- reset state ----------------
    #1 trst = 1'b1;
    #2;
    check_eq("rst_tlr", s_tlr, 1'b1);
    check_eq("rst_other_states", {s_rti, s_cdr, s_sdr, s_pdr, s_udr, s_sir, s_e1ir, s_uir}, 8'h00);
    check_eq("rst_latched", latched_jtag_ir, 4'b0010);
    check_eq("rst_sel", {sel_bs_chain, sel_pixel_sr, sel_global_sr}, 3'b000);
    check_eq("rst_idcode_reg", dut.idcode_q, 32'h0);
    #9 trst = 1'b0;
    step(1'b1, 1'b0);
    check_eq("tlr_hold", s_tlr, 1'b1);
    step(1'b0, 1'b0);
    check_eq("to_rti", s_rti, 1'b1);

    // ---------------- IDCODE full scan ----------------
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("cap_dr", s_cdr, 1'b1);
    step(1'b0, 1'b0);
    check_eq("sh_dr", s_sdr, 1'b1);
    for (int i = 0; i < 32; i++) begin
      stream[i] = idcode_tdo;
      step((i == 31) ? 1'b1 : 1'b0, 1'b0);
    end
    check_eq("idcode_stream", stream, IDC);
    check_eq("idcode_after", dut.idcode_q, 32'h0);
    step(1'b1, 1'b0);
    check_eq("upd_dr", s_udr, 1'b1);
    step(1'b0, 1'b0);
    check_eq("back_rti", s_rti, 1'b1);

    // ---------------- pause-DR hold ----------------
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b0); exp_id = IDC;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0); exp_id = {1'b0, exp_id[31:1]};
    end
    step(1'b1, 1'b0); exp_id = {1'b0, exp_id[31:1]};
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check_eq("pause_dr", s_pdr, 1'b1);
      check_eq("pause_hold", dut.idcode_q, exp_id);
      step(1'b0, 1'b1);
    end
    check_eq("pause_dr_last", s_pdr, 1'b1);
    step(1'b1, 1'b0);
    check_eq("ex2_not_pause", s_pdr, 1'b0);
    step(1'b0, 1'b0);
    check_eq("resume_sh_dr", s_sdr, 1'b1);
    check_eq("resume_reg", dut.idcode_q, exp_id);
    step(1'b0, 1'b1); exp_id = {1'b1, exp_id[31:1]};
    check_eq("resume_shift", dut.idcode_q, exp_id);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // ---------------- IR load 0100 with capture stream ----------------
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    check_eq("sh_ir", s_sir, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ir_stream[i] = instruction_tdo;
      step((i == 3) ? 1'b1 : 1'b0, (i == 2) ? 1'b1 : 1'b0);
    end
    check_eq("ir_capture_stream", ir_stream, 4'b0001);
    check_eq("ex1_ir", s_e1ir, 1'b1);
    check_eq("latched_before_upd", latched_jtag_ir, 4'b0010);
    step(1'b1, 1'b0);
    check_eq("upd_ir", s_uir, 1'b1);
    step(1'b0, 1'b0);
    check_eq("latched_global", latched_jtag_ir, 4'b0100);
    check_eq("sel_global", {sel_bs_chain, sel_pixel_sr, sel_global_sr}, 3'b001);

    // ---------------- trst mid Shift-IR ----------------
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    check_eq("sh_ir_before_trst", s_sir, 1'b1);
    #2 trst = 1'b1;
    #1;
    check_eq("trst_async_tlr", s_tlr, 1'b1);
    check_eq("trst_not_sh_ir", s_sir, 1'b0);
    check_eq("trst_latched", latched_jtag_ir, 4'b0010);
    check_eq("trst_jtag_ir", dut.jtag_ir_q, 4'b0000);
    check_eq("trst_sel", {sel_bs_chain, sel_pixel_sr, sel_global_sr}, 3'b000);
    #2 trst = 1'b0;
    step(1'b0, 1'b0);
    check_eq("trst_to_rti", s_rti, 1'b1);

    // ---------------- pixel select then tms reset ----------------
    load_ir(4'b1000);
    check_eq("latched_pixel", latched_jtag_ir, 4'b1000);
    check_eq("sel_pixel", {sel_bs_chain, sel_pixel_sr, sel_global_sr}, 3'b010);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check_eq("tms_reset_tlr", s_tlr, 1'b1);
    check_eq("tms_reset_latched", latched_jtag_ir, 4'b0010);
    check_eq("tms_reset_sel_pixel", sel_pixel_sr, 1'b0);
    step(1'b0, 1'b0);

    // ---------------- unknown / boundary-scan decodes ----------------
    load_ir(4'b1111);
    check_eq("latched_1111", latched_jtag_ir, 4'b1111);
    check_eq("sel_unknown", {sel_bs_chain, sel_pixel_sr, sel_global_sr}, 3'b000);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b1, 1'b1);
    check_eq("idcode_hold_other_ir", dut.idcode_q, 32'h0);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    load_ir(4'b0001);
    check_eq("sel_sample", {sel_bs_chain, sel_pixel_sr, sel_global_sr}, 3'b100);
    load_ir(4'b0000);
    check_eq("sel_extest", {sel_bs_chain, sel_pixel_sr, sel_global_sr}, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
